// File: rtl/plic_pkg.sv
// Shared definitions for the PLIC core: default sizing, register map offsets
// and the per-source gateway state encoding.
package plic_pkg;

  localparam int NSRC_DEF   = 31;
  localparam int NCTX_DEF   = 2;
  localparam int PRIO_W_DEF = 3;

  localparam logic [25:0] PEND_ADDR  = 26'h001000;
  localparam logic [25:0] EN_BASE    = 26'h002000;
  localparam logic [25:0] EN_STRIDE  = 26'h000080;
  localparam logic [25:0] CTX_BASE   = 26'h200000;
  localparam logic [25:0] CTX_STRIDE = 26'h001000;
  localparam logic [25:0] CLAIM_OFF  = 26'h000004;

  typedef enum logic [1:0] {
    GW_IDLE     = 2'd0,
    GW_PENDING  = 2'd1,
    GW_INFLIGHT = 2'd2
  } gw_state_e;

  function automatic logic [25:0] en_addr(input int c);
    return EN_BASE + EN_STRIDE * 26'(c);
  endfunction

  function automatic logic [25:0] thr_addr(input int c);
    return CTX_BASE + CTX_STRIDE * 26'(c);
  endfunction

endpackage

// File: rtl/plic_gateway.sv
// Per-source interrupt gateway: latches a level request, holds it while a
// claim is outstanding and re-arms only after the matching complete.
module plic_gateway
  import plic_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic irq_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic pending_o
);

  gw_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= GW_IDLE;
    else     state_q <= state_d;
  end

  // Only the current state decides which event matters, so a complete
  // arriving while still PENDING is dropped and INFLIGHT ignores the line.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      GW_IDLE:     if (irq_i)      state_d = GW_PENDING;
      GW_PENDING:  if (claim_i)    state_d = GW_INFLIGHT;
      GW_INFLIGHT: if (complete_i) state_d = GW_IDLE;
      default:                     state_d = GW_IDLE;
    endcase
  end

  assign pending_o = (state_q == GW_PENDING);

endmodule

// File: rtl/plic_core.sv
// PLIC core: register file, per-context highest-priority selection, claim and
// complete handling, and registered external interrupt outputs. NSRC <= 31.
module plic_core
  import plic_pkg::*;
#(
  parameter int NSRC   = NSRC_DEF,
  parameter int NCTX   = NCTX_DEF,
  parameter int PRIO_W = PRIO_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [25:0]       reg_addr,
  input  logic              reg_read,
  input  logic              reg_write,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata,
  input  logic [NSRC:0]     irq_src,
  output logic [NCTX-1:0]   eip
);

  localparam int ID_W = $clog2(NSRC + 1);

  logic [NSRC:0][PRIO_W-1:0]   prio_q, prio_d;
  logic [NCTX-1:0][NSRC:0]     en_q, en_d;
  logic [NCTX-1:0][PRIO_W-1:0] thr_q, thr_d;
  logic [NCTX-1:0][ID_W-1:0]   cand_id_q, cand_id_d;
  logic [NCTX-1:0][PRIO_W-1:0] cand_prio_q, cand_prio_d;
  logic [NCTX-1:0]             eip_q, eip_d;

  logic [NSRC:0]               pend, claim_vec, comp_vec;
  logic [NCTX-1:0][ID_W-1:0]   claim_id;

  logic                        prio_hit;
  logic [ID_W-1:0]             prio_sel;
  logic [NCTX-1:0]             en_hit, thr_hit, cc_hit;
  logic                        unused_bits;

  // ---------------- address decode ----------------
  assign prio_sel = reg_addr[ID_W+1:2];
  assign prio_hit = (reg_addr[25:12] == '0) && (reg_addr[1:0] == 2'b00) &&
                    (reg_addr[11:2] != '0) && (32'(reg_addr[11:2]) <= NSRC);

  always_comb begin
    en_hit  = '0;
    thr_hit = '0;
    cc_hit  = '0;
    for (int c = 0; c < NCTX; c++) begin
      en_hit[c]  = (reg_addr == en_addr(c));
      thr_hit[c] = (reg_addr == thr_addr(c));
      cc_hit[c]  = (reg_addr == thr_addr(c) + CLAIM_OFF);
    end
  end

  // ---------------- gateways ----------------
  assign pend[0] = 1'b0;

  for (genvar g = 1; g <= NSRC; g++) begin : g_gw
    plic_gateway u_gw (
      .clk        (clk),
      .rst        (rst),
      .irq_i      (irq_src[g]),
      .claim_i    (claim_vec[g]),
      .complete_i (comp_vec[g]),
      .pending_o  (pend[g])
    );
  end

  assign unused_bits = ^{irq_src[0], claim_vec[0], comp_vec[0]};

  // ---------------- claim / complete ----------------
  // The claim answer uses the registered candidate; if that source has
  // already left PENDING the claim returns 0 and has no side effect.
  always_comb begin
    claim_id = '0;
    for (int c = 0; c < NCTX; c++)
      if ((cand_prio_q[c] > thr_q[c]) && pend[cand_id_q[c]])
        claim_id[c] = cand_id_q[c];
  end

  always_comb begin
    claim_vec = '0;
    comp_vec  = '0;
    for (int c = 0; c < NCTX; c++) begin
      if (reg_read && cc_hit[c] && (claim_id[c] != '0))
        claim_vec[claim_id[c]] = 1'b1;
      if (reg_write && cc_hit[c])
        for (int i = 1; i <= NSRC; i++)
          if ((reg_wdata == 32'(i)) && en_q[c][i]) comp_vec[i] = 1'b1;
    end
  end

  // ---------------- register writes ----------------
  always_comb begin
    prio_d = prio_q;
    en_d   = en_q;
    thr_d  = thr_q;
    if (reg_write) begin
      if (prio_hit) prio_d[prio_sel] = reg_wdata[PRIO_W-1:0];
      for (int c = 0; c < NCTX; c++) begin
        if (en_hit[c])  en_d[c]  = {reg_wdata[NSRC:1], 1'b0};
        if (thr_hit[c]) thr_d[c] = reg_wdata[PRIO_W-1:0];
      end
    end
  end

  // ---------------- candidate selection ----------------
  // Scanning from the top ID down with >= leaves the lowest ID on ties.
  always_comb begin
    cand_id_d   = '0;
    cand_prio_d = '0;
    eip_d       = '0;
    for (int c = 0; c < NCTX; c++) begin
      for (int i = NSRC; i >= 1; i--) begin
        if (pend[i] && en_q[c][i] && (prio_q[i] != '0) &&
            (prio_q[i] >= cand_prio_d[c])) begin
          cand_id_d[c]   = ID_W'(i);
          cand_prio_d[c] = prio_q[i];
        end
      end
      eip_d[c] = (cand_prio_q[c] > thr_q[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q      <= '0;
      en_q        <= '0;
      thr_q       <= '0;
      cand_id_q   <= '0;
      cand_prio_q <= '0;
      eip_q       <= '0;
    end else begin
      prio_q      <= prio_d;
      en_q        <= en_d;
      thr_q       <= thr_d;
      cand_id_q   <= cand_id_d;
      cand_prio_q <= cand_prio_d;
      eip_q       <= eip_d;
    end
  end

  assign eip = eip_q;

  // ---------------- read mux ----------------
  always_comb begin
    reg_rdata = '0;
    if (prio_hit)                reg_rdata = 32'(prio_q[prio_sel]);
    if (reg_addr == PEND_ADDR)   reg_rdata = 32'(pend);
    for (int c = 0; c < NCTX; c++) begin
      if (en_hit[c])  reg_rdata = 32'(en_q[c]);
      if (thr_hit[c]) reg_rdata = 32'(thr_q[c]);
      if (cc_hit[c])  reg_rdata = 32'(claim_id[c]);
    end
  end

endmodule
